regfile_wb_arbiter: RTL

- Shares the register file's single write port (we/WriteAddr/WriteData) between two writeback requesters: the ALU path and the load/store (LSU) path.
- Keeps a 32-entry pending-write scoreboard, set at issue and cleared at commit, and drives read-operand hazard flags to the issue stage.
- Sits between the execute/memory stages and the Registers block.
- The write port is driven from registers.

---
 rtl/regfile_wb_arbiter_pkg.sv | 31 +++
 rtl/regfile_wb_arbiter_wb_scoreboard.sv | 100 ++++++++++
 rtl/regfile_wb_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file writeback arbiter and its
// pending-write scoreboard.
//   REG_ADDR_W / XLEN / NUM_REGS : register file geometry
//   REG_ZERO                     : hard-wired zero register address
//   wb_sel_e                     : which requester owns the write port
//   addr_onehot()                : register address -> one-hot bit vector
// ----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_LSU = 1'b1
    } wb_sel_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // One-hot decode of a register address into a scoreboard-wide mask.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t a);
        addr_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// ----------------------------------------------------------------------------
// wb_scoreboard
// 32-entry pending-write scoreboard. A bit is set when the issue stage
// reserves a destination and cleared when the write port commits it.
// Provides read-operand hazard flags and a sticky WAW error flag.
// Optional macro WB_BYPASS_EN adds forwarding lookups against the write
// port that is active this cycle; those hits suppress the matching hazard.
// Ports:
//   clk, rst                       clock, async active-low reset
//   i_rsv_valid, i_rsv_addr        reservation request from issue
//   i_clr_en, i_clr_addr           write port enable/address (commit)
//   i_rs1_addr, i_rs2_addr         operand lookups
//   o_busy                         scoreboard vector (bit 0 always 0)
//   o_waw_err                      sticky reserve-while-busy flag
//   o_hazard1, o_hazard2           operand pending-write flags
//   (WB_BYPASS_EN) i_wb_data, o_fwd1_hit/o_fwd1_data, o_fwd2_hit/o_fwd2_data
// ----------------------------------------------------------------------------
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rsv_valid,
    input  logic [REG_ADDR_W-1:0] i_rsv_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
`ifdef WB_BYPASS_EN
    input  logic [XLEN-1:0]       i_wb_data,
    output logic                  o_fwd1_hit,
    output logic [XLEN-1:0]       o_fwd1_data,
    output logic                  o_fwd2_hit,
    output logic [XLEN-1:0]       o_fwd2_data,
`endif
    output logic [NUM_REGS-1:0]   o_busy,
    output logic                  o_waw_err,
    output logic                  o_hazard1,
    output logic                  o_hazard2
);

    logic [NUM_REGS-1:0] r_busy;
    logic                r_waw_err;
    logic [NUM_REGS-1:0] w_rsv_vec;
    logic [NUM_REGS-1:0] w_clr_vec;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_waw_set;
    logic                w_fwd1_hit;
    logic                w_fwd2_hit;

    // Next scoreboard value: clear the committing register, then apply the
    // reservation so that a same-edge reserve of that register wins.
    always_comb begin
        w_rsv_vec = {NUM_REGS{1'b0}};
        w_clr_vec = {NUM_REGS{1'b0}};
        if (i_rsv_valid && (i_rsv_addr != REG_ZERO)) begin
            w_rsv_vec = addr_onehot(i_rsv_addr);
        end else begin
            w_rsv_vec = {NUM_REGS{1'b0}};
        end
        if (i_clr_en) begin
            w_clr_vec = addr_onehot(i_clr_addr);
        end else begin
            w_clr_vec = {NUM_REGS{1'b0}};
        end
        // x0 can never be pending.
        w_busy_nxt = ((r_busy & ~w_clr_vec) | w_rsv_vec) & {{(NUM_REGS-1){1'b1}}, 1'b0};
        // Reserving a register that stays busy through this edge is a WAW.
        w_waw_set  = |(w_rsv_vec & r_busy & ~w_clr_vec);
    end

    // Scoreboard and sticky WAW flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= {NUM_REGS{1'b0}};
            r_waw_err <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_waw_err <= r_waw_err | w_waw_set;
        end
    end

`ifdef WB_BYPASS_EN
    assign w_fwd1_hit  = i_clr_en && (i_clr_addr == i_rs1_addr) && (i_rs1_addr != REG_ZERO);
    assign w_fwd2_hit  = i_clr_en && (i_clr_addr == i_rs2_addr) && (i_rs2_addr != REG_ZERO);
    assign o_fwd1_hit  = w_fwd1_hit;
    assign o_fwd2_hit  = w_fwd2_hit;
    assign o_fwd1_data = i_wb_data;
    assign o_fwd2_data = i_wb_data;
`else
    assign w_fwd1_hit  = 1'b0;
    assign w_fwd2_hit  = 1'b0;
`endif

    assign o_hazard1 = r_busy[i_rs1_addr] && (i_rs1_addr != REG_ZERO) && !w_fwd1_hit;
    assign o_hazard2 = r_busy[i_rs2_addr] && (i_rs2_addr != REG_ZERO) && !w_fwd2_hit;
    assign o_busy    = r_busy;
    assign o_waw_err = r_waw_err;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU and LSU
// writeback paths. ALU has fixed priority; an LSU request refused MAX_WAIT
// times in a row is granted over the ALU. The write port is registered
// (one cycle after the transfer). A pending-write scoreboard (wb_scoreboard)
// reports read-operand hazards to the issue stage.
// Optional macro WB_BYPASS_EN: adds fwd1/fwd2 hit+data outputs that forward
// the active write port and suppress the matching hazard.
// Ports:
//   clk, rst                                 clock, async active-low reset
//   alu_valid/alu_ready/alu_addr/alu_data    ALU writeback handshake
//   lsu_valid/lsu_ready/lsu_addr/lsu_data    LSU writeback handshake
//   rsv_valid/rsv_addr                       destination reservation
//   rs1_addr/rs2_addr -> hazard1/hazard2     operand hazard lookup
//   wb_we/wb_addr/wb_data                    register file write port
//   busy, waw_err                            scoreboard state
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_addr,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  hazard1,
    output logic                  hazard2,
`ifdef WB_BYPASS_EN
    output logic                  fwd1_hit,
    output logic [XLEN-1:0]       fwd1_data,
    output logic                  fwd2_hit,
    output logic [XLEN-1:0]       fwd2_data,
`endif
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  waw_err
);

    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  r_wb_we;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [XLEN-1:0]       r_wb_data;

    logic                  w_force;
    logic                  w_alu_ready;
    logic                  w_lsu_ready;
    logic                  w_alu_xfer;
    logic                  w_lsu_xfer;
    wb_sel_e               w_sel;
    logic [REG_ADDR_W-1:0] w_win_addr;
    logic [XLEN-1:0]       w_win_data;

    // The two grants are mutually exclusive by construction: without force the
    // LSU is only ready when the ALU is idle; with force the ALU is held off
    // whenever the LSU is requesting.
    assign w_force     = (r_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_alu_ready = !(w_force && lsu_valid);
    assign w_lsu_ready = w_force || !alu_valid;
    assign w_alu_xfer  = alu_valid && w_alu_ready;
    assign w_lsu_xfer  = lsu_valid && w_lsu_ready;

    // Winner select for the write stage.
    always_comb begin
        w_sel      = SEL_ALU;
        w_win_addr = alu_addr;
        w_win_data = alu_data;
        case (w_sel_from_xfer(w_lsu_xfer))
            SEL_LSU: begin
                w_sel      = SEL_LSU;
                w_win_addr = lsu_addr;
                w_win_data = lsu_data;
            end
            SEL_ALU: begin
                w_sel      = SEL_ALU;
                w_win_addr = alu_addr;
                w_win_data = alu_data;
            end
            default: begin
                w_sel      = SEL_ALU;
                w_win_addr = alu_addr;
                w_win_data = alu_data;
            end
        endcase
    end

    function automatic wb_sel_e w_sel_from_xfer(input logic lsu_xfer);
        w_sel_from_xfer = lsu_xfer ? SEL_LSU : SEL_ALU;
    endfunction

    // LSU starvation counter: counts consecutive refused LSU cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (w_lsu_xfer || !lsu_valid) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (!w_force) begin
            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Registered write port; writes to x0 are accepted but never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_we   <= 1'b0;
            r_wb_addr <= REG_ZERO;
            r_wb_data <= {XLEN{1'b0}};
        end else if (w_alu_xfer || w_lsu_xfer) begin
            r_wb_we   <= (w_win_addr != REG_ZERO);
            r_wb_addr <= w_win_addr;
            r_wb_data <= w_win_data;
        end else begin
            r_wb_we   <= 1'b0;
            r_wb_addr <= r_wb_addr;
            r_wb_data <= r_wb_data;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_rsv_valid (rsv_valid),
        .i_rsv_addr  (rsv_addr),
        .i_clr_en    (r_wb_we),
        .i_clr_addr  (r_wb_addr),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
`ifdef WB_BYPASS_EN
        .i_wb_data   (r_wb_data),
        .o_fwd1_hit  (fwd1_hit),
        .o_fwd1_data (fwd1_data),
        .o_fwd2_hit  (fwd2_hit),
        .o_fwd2_data (fwd2_data),
`endif
        .o_busy      (busy),
        .o_waw_err   (waw_err),
        .o_hazard1   (hazard1),
        .o_hazard2   (hazard2)
    );

    assign alu_ready = w_alu_ready;
    assign lsu_ready = w_lsu_ready;
    assign wb_we     = r_wb_we;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;

endmodule
